i2c_reg_arbiter: RTL and testbench

- Shares a single-port register memory between the I2C peripheral's register read/write handshake and a local host requester.
- Sequences every memory access: grant, issue, fixed-latency read capture, return handshake.
- Sits between i2c_peripheral and the register bank; the peripheral's read_enable/read_valid/read_ack and write_valid/write_ack pairs terminate here.

---
 rtl/i2c_pkg.sv | 16 +
 rtl/i2c_reg_grant.sv | 42 ++++
 rtl/i2c_reg_arbiter.sv | 109 ++++++++++
 tb/tb_i2c_reg_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C register arbiter: FSM states, access owner and
// the latched request that travels with an in-flight memory access.
package i2c_pkg;
  localparam int REG_ADDR_W = 8;
  localparam int REG_DATA_W = 8;

  typedef enum logic [2:0] {IDLE, ISSUE_WR, ISSUE_RD, WAIT_RD, PRESENT, RECOVER} arb_state_t;
  typedef enum logic {OWN_I2C, OWN_HOST} owner_t;

  typedef struct packed {
    owner_t                owner;
    logic                  is_rd;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] wdata;
  } arb_req_t;
endpackage

// File: rtl/i2c_reg_grant.sv
// Priority between the I2C handshake and the host, with a starvation counter
// that forces the host in once HOST_MAX_WAIT I2C grants have gone by.
module i2c_reg_grant import i2c_pkg::*; #(
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic   sys_clk,
  input  logic   rst_n,
  input  logic   arb_en,
  input  logic   i2c_rd,
  input  logic   i2c_wr,
  input  logic   host_req,
  input  logic   host_we,
  output logic   grant,
  output owner_t owner,
  output logic   is_rd
);
  localparam int CNT_W = $clog2(HOST_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOST_MAX_WAIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             i2c_req, force_host, pick_i2c, pick_host;

  always_comb begin
    i2c_req    = i2c_rd | i2c_wr;
    force_host = host_req && (starve_cnt == CNT_MAX);
    pick_i2c   = i2c_req && !force_host;
    pick_host  = !pick_i2c && host_req;
    grant      = arb_en && (pick_i2c || pick_host);
    owner      = pick_i2c ? OWN_I2C : OWN_HOST;
    // read wins when the I2C side raises both
    is_rd      = pick_i2c ? i2c_rd : !host_we;
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n || !host_req)
      starve_cnt <= '0;
    else if (arb_en && pick_host)
      starve_cnt <= '0;
    else if (arb_en && pick_i2c && starve_cnt != CNT_MAX)
      starve_cnt <= starve_cnt + 1'b1;
  end
endmodule

// File: rtl/i2c_reg_arbiter.sv
// Shares one single-port register memory between the I2C peripheral and a
// local host; each access runs grant -> issue -> (read wait) -> return.
module i2c_reg_arbiter import i2c_pkg::*; #(
  parameter int MEM_READ_LATENCY = 1,
  parameter int HOST_MAX_WAIT    = 4
) (
  input  logic                  i_sys_clk,
  input  logic                  i_rst_n,
  input  logic [REG_ADDR_W-1:0] i_i2c_reg_addr,
  input  logic                  i_i2c_read_enable,
  output logic [REG_DATA_W-1:0] o_i2c_read_data,
  output logic                  o_i2c_read_valid,
  input  logic                  i_i2c_read_ack,
  input  logic [REG_DATA_W-1:0] i_i2c_write_data,
  input  logic                  i_i2c_write_valid,
  output logic                  o_i2c_write_ack,
  input  logic                  i_host_req,
  input  logic                  i_host_we,
  input  logic [REG_ADDR_W-1:0] i_host_addr,
  input  logic [REG_DATA_W-1:0] i_host_wdata,
  output logic [REG_DATA_W-1:0] o_host_rdata,
  output logic                  o_host_done,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [REG_ADDR_W-1:0] o_mem_addr,
  output logic [REG_DATA_W-1:0] o_mem_wdata,
  input  logic [REG_DATA_W-1:0] i_mem_rdata
);
  arb_state_t            state, state_nxt;
  arb_req_t              req_q;
  logic [1:0]            wait_cnt;
  logic [REG_DATA_W-1:0] i2c_rdata_q, host_rdata_q;
  logic                  host_rd_done_q;
  logic                  grant, g_is_rd, rd_capture;
  owner_t                g_owner;

  i2c_reg_grant #(.HOST_MAX_WAIT(HOST_MAX_WAIT)) u_grant (
    .sys_clk  (i_sys_clk),
    .rst_n    (i_rst_n),
    .arb_en   (state == IDLE),
    .i2c_rd   (i_i2c_read_enable),
    .i2c_wr   (i_i2c_write_valid),
    .host_req (i_host_req),
    .host_we  (i_host_we),
    .grant    (grant),
    .owner    (g_owner),
    .is_rd    (g_is_rd)
  );

  assign rd_capture = (state == WAIT_RD) && (wait_cnt == 2'd0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (grant) state_nxt = g_is_rd ? ISSUE_RD : ISSUE_WR;
      ISSUE_WR: state_nxt = RECOVER;
      ISSUE_RD: state_nxt = WAIT_RD;
      WAIT_RD:  if (rd_capture) state_nxt = (req_q.owner == OWN_I2C) ? PRESENT : RECOVER;
      // a dropped read_enable is a STOP/START abort: leave without an ack
      PRESENT:  if (!i_i2c_read_enable || i_i2c_read_ack) state_nxt = RECOVER;
      RECOVER:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      req_q          <= '0;
      wait_cnt       <= '0;
      i2c_rdata_q    <= '0;
      host_rdata_q   <= '0;
      host_rd_done_q <= 1'b0;
    end else begin
      state          <= state_nxt;
      host_rd_done_q <= 1'b0;
      if (state == IDLE && grant) begin
        req_q.owner <= g_owner;
        req_q.is_rd <= g_is_rd;
        req_q.addr  <= (g_owner == OWN_I2C) ? i_i2c_reg_addr : i_host_addr;
        req_q.wdata <= (g_owner == OWN_I2C) ? i_i2c_write_data : i_host_wdata;
      end
      if (state == ISSUE_RD)
        wait_cnt <= 2'(MEM_READ_LATENCY - 1);
      else if (state == WAIT_RD && wait_cnt != 2'd0)
        wait_cnt <= wait_cnt - 2'd1;
      if (rd_capture) begin
        if (req_q.owner == OWN_I2C) begin
          i2c_rdata_q <= i_mem_rdata;
        end else begin
          host_rdata_q   <= i_mem_rdata;
          host_rd_done_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_mem_en         = (state == ISSUE_WR) || (state == ISSUE_RD);
    o_mem_we         = (state == ISSUE_WR);
    o_mem_addr       = o_mem_en ? req_q.addr : '0;
    o_mem_wdata      = o_mem_we ? req_q.wdata : '0;
    o_i2c_write_ack  = (state == ISSUE_WR) && (req_q.owner == OWN_I2C);
    o_host_done      = ((state == ISSUE_WR) && (req_q.owner == OWN_HOST)) || host_rd_done_q;
    o_i2c_read_valid = (state == PRESENT);
    o_i2c_read_data  = i2c_rdata_q;
    o_host_rdata     = host_rdata_q;
  end
endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Directed bench for i2c_reg_arbiter with a 2-cycle-latency memory model.
module tb_i2c_reg_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i2c_addr, i2c_wdata, host_addr, host_wdata, mem_rdata;
  logic       i2c_ren, i2c_ack, i2c_wval, host_req, host_we;
  logic [7:0] i2c_rdata, host_rdata, mem_addr, mem_wdata;
  logic       i2c_rval, i2c_wack, host_done, mem_en, mem_we;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] mem [256];
  logic [7:0] rd_pipe [2];

  always #5 clk = ~clk;

  i2c_reg_arbiter #(.MEM_READ_LATENCY(2), .HOST_MAX_WAIT(4)) dut (
    .i_sys_clk         (clk),
    .i_rst_n           (rst_n),
    .i_i2c_reg_addr    (i2c_addr),
    .i_i2c_read_enable (i2c_ren),
    .o_i2c_read_data   (i2c_rdata),
    .o_i2c_read_valid  (i2c_rval),
    .i_i2c_read_ack    (i2c_ack),
    .i_i2c_write_data  (i2c_wdata),
    .i_i2c_write_valid (i2c_wval),
    .o_i2c_write_ack   (i2c_wack),
    .i_host_req        (host_req),
    .i_host_we         (host_we),
    .i_host_addr       (host_addr),
    .i_host_wdata      (host_wdata),
    .o_host_rdata      (host_rdata),
    .o_host_done       (host_done),
    .o_mem_en          (mem_en),
    .o_mem_we          (mem_we),
    .o_mem_addr        (mem_addr),
    .o_mem_wdata       (mem_wdata),
    .i_mem_rdata       (mem_rdata)
  );

  // Read data is valid exactly 2 cycles after the read strobe, garbage otherwise.
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 8'hEE;
    rd_pipe[1] <= rd_pipe[0];
  end
  assign mem_rdata = rd_pipe[1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_rval"}, i2c_rval, 0);
    chk({tag, "_done"}, host_done, 0);
    chk({tag, "_wack"}, i2c_wack, 0);
    chk({tag, "_rdata"}, i2c_rdata, 0);
    chk({tag, "_hrdata"}, host_rdata, 0);
    chk({tag, "_maddr"}, mem_addr, 0);
  endtask

  // Waits for read_valid, bounded; returns cycles spent.
  task automatic wait_rval(input string tag, output int c);
    c = 0;
    while (!i2c_rval && c < 20) begin @(negedge clk); c++; end
    chk({tag, "_rval_seen"}, i2c_rval, 1);
  endtask

  initial begin
    int c, acks, acks_at, dones;
    bit seen;
    rst_n = 0; i2c_addr = 0; i2c_wdata = 0; host_addr = 0; host_wdata = 0;
    i2c_ren = 0; i2c_ack = 0; i2c_wval = 0; host_req = 0; host_we = 0;
    nc(3);
    chk_idle_outs("reset");
    rst_n = 1;
    nc(1);

    // host write preloads mem[0x22]=0x5C; done in the issue cycle
    host_req = 1; host_we = 1; host_addr = 8'h22; host_wdata = 8'h5C;
    nc(1);
    chk("hw_en", {mem_en, mem_we}, 2'b11);
    chk("hw_addr", mem_addr, 8'h22);
    chk("hw_done", host_done, 1);
    host_req = 0;
    nc(1);
    chk("hw_done_pulse", host_done, 0);
    nc(1);

    // I2C write 0x10 <= 0xA5
    i2c_wval = 1; i2c_addr = 8'h10; i2c_wdata = 8'hA5;
    nc(1);
    chk("iw_en", {mem_en, mem_we}, 2'b11);
    chk("iw_addr", mem_addr, 8'h10);
    chk("iw_data", mem_wdata, 8'hA5);
    chk("iw_ack", i2c_wack, 1);
    nc(1);
    chk("iw_ack_pulse", i2c_wack, 0);
    chk("iw_mem", mem[8'h10], 8'hA5);
    i2c_wval = 0;
    nc(1);
    chk("iw_no_reissue", mem_en, 0);

    // I2C read 0x22: valid rises 4 cycles after the request
    i2c_ren = 1; i2c_addr = 8'h22;
    for (int i = 1; i <= 3; i++) begin
      nc(1);
      if (i == 1) chk("ir_issue", {mem_en, mem_we, mem_addr}, {2'b10, 8'h22});
      chk("ir_early_valid", i2c_rval, 0);
    end
    nc(1);
    chk("ir_valid", i2c_rval, 1);
    chk("ir_data", i2c_rdata, 8'h5C);
    nc(1);
    chk("ir_valid_hold", i2c_rval, 1);
    chk("ir_data_hold", i2c_rdata, 8'h5C);
    i2c_ack = 1;
    nc(1);
    chk("ir_valid_drop", i2c_rval, 0);
    i2c_ack = 0; i2c_ren = 0;
    nc(1);

    // starvation: host read of 0x22 pending while I2C writes back to back
    host_req = 1; host_we = 0; host_addr = 8'h22;
    i2c_wval = 1; i2c_addr = 8'h40; i2c_wdata = 8'h11;
    c = 0; acks = 0; acks_at = -1; seen = 0;
    while (!host_done && c < 60) begin
      nc(1); c++;
      if (i2c_wack) acks++;
      if (mem_en && !mem_we && !seen) begin seen = 1; acks_at = acks; end
    end
    chk("st_done_seen", host_done, 1);
    chk("st_i2c_grants", acks_at, 4);
    chk("st_rdata", host_rdata, 8'h5C);
    host_req = 0; i2c_wval = 0;
    dones = 0;
    for (int i = 0; i < 5; i++) begin nc(1); if (host_done) dones++; end
    chk("st_done_once", dones, 0);
    chk("st_rdata_hold", host_rdata, 8'h5C);

    // read abort from PRESENT, then a normal read
    i2c_ren = 1; i2c_addr = 8'h10;
    wait_rval("ab", c);
    chk("ab_data", i2c_rdata, 8'hA5);
    i2c_ren = 0;
    nc(1);
    chk("ab_valid_drop", i2c_rval, 0);
    i2c_ren = 1; i2c_addr = 8'h40;
    wait_rval("ab2", c);
    chk("ab2_data", i2c_rdata, 8'h11);
    i2c_ack = 1;
    nc(1);
    i2c_ack = 0; i2c_ren = 0;
    nc(1);

    // simultaneous writes to 0x30: I2C first, host second
    i2c_wval = 1; i2c_addr = 8'h30; i2c_wdata = 8'h33;
    host_req = 1; host_we = 1; host_addr = 8'h30; host_wdata = 8'h77;
    nc(1);
    chk("sim_i2c_first", {i2c_wack, host_done, mem_wdata}, {2'b10, 8'h33});
    i2c_wval = 0;
    nc(3);
    chk("sim_host_second", {i2c_wack, host_done, mem_wdata}, {2'b01, 8'h77});
    host_req = 0;
    nc(1);
    chk("sim_final_mem", mem[8'h30], 8'h77);
    nc(1);

    // reset while in WAIT_RD
    i2c_ren = 1; i2c_addr = 8'h22;
    nc(2);
    rst_n = 0;
    nc(1);
    chk_idle_outs("rstrd");
    i2c_ren = 0;
    nc(1);
    rst_n = 1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin nc(1); if (host_done || i2c_rval) dones++; end
    chk("rstrd_no_out", dones, 0);
    i2c_ren = 1; i2c_addr = 8'h10;
    wait_rval("rstrd2", c);
    chk("rstrd2_lat", c, 4);
    chk("rstrd2_data", i2c_rdata, 8'hA5);
    i2c_ack = 1;
    nc(1);
    i2c_ack = 0; i2c_ren = 0;
    nc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
